// File: rtl/mxint8_block_dequant_serializer_pkg.sv
// Shared constants, state encoding and helpers for the MXINT8 -> float32 return path.
package mxint8_block_dequant_serializer_pkg;

  localparam int unsigned MX_BLOCK_SIZE        = 32;
  localparam int unsigned SCALE_WIDTH          = 8;
  localparam int unsigned MXINT8_ELEMENT_WIDTH = 8;
  localparam int unsigned MXINT8_FRAC_BITS     = 6;

  localparam int unsigned FLOAT32_WIDTH      = 32;
  localparam int unsigned FLOAT32_EXP_WIDTH  = 8;
  localparam int unsigned FLOAT32_MANT_WIDTH = 23;
  localparam int unsigned FLOAT32_EXP_MAX    = (1 << FLOAT32_EXP_WIDTH) - 1;

  localparam logic [SCALE_WIDTH-1:0]   SCALE_NAN       = 8'hFF;
  localparam logic [FLOAT32_WIDTH-1:0] FLOAT32_QNAN    = 32'h7FC00000;
  localparam logic [FLOAT32_WIDTH-1:0] FLOAT32_NEG_MAX = 32'hFF7FFFFF;

  // Subnormal mantissa = m << (scale + SUBNORMAL_SHIFT_BIAS): aligns 2^(s-127-6) to the 2^-149 LSB.
  localparam int unsigned SUBNORMAL_SHIFT_BIAS = FLOAT32_MANT_WIDTH - 1 - MXINT8_FRAC_BITS;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  function automatic logic [2:0] leading_one(input logic [MXINT8_ELEMENT_WIDTH-1:0] m);
    logic [2:0] pos;
    pos = '0;
    for (int unsigned i = 0; i < MXINT8_ELEMENT_WIDTH; i++) begin
      if (m[i]) pos = 3'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/mxint8_element_to_float32.sv
// Exact conversion of one MXINT8 element (with shared E8M0 scale) to IEEE-754 float32.
module mxint8_element_to_float32
  import mxint8_block_dequant_serializer_pkg::*;
(
  input  logic [SCALE_WIDTH-1:0]          scale,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] element,
  output logic [FLOAT32_WIDTH-1:0]        float32
);

  logic                            sign;
  logic [MXINT8_ELEMENT_WIDTH-1:0] mag;
  logic [2:0]                      lead;
  logic signed [9:0]               exp_unb;
  logic [FLOAT32_MANT_WIDTH-1:0]   mant_norm;
  logic [FLOAT32_MANT_WIDTH-1:0]   mant_sub;
  logic [8:0]                      sub_amt;
  logic [4:0]                      norm_amt;

  always_comb begin
    sign = element[MXINT8_ELEMENT_WIDTH-1];
    // 8-bit negate of 0x80 yields 0x80, which is the correct magnitude 128.
    mag  = sign ? MXINT8_ELEMENT_WIDTH'(-element) : element;
    lead = leading_one(mag);

    exp_unb = $signed({2'b00, scale}) + $signed({7'b0000000, lead})
            - $signed(10'(MXINT8_FRAC_BITS));

    norm_amt  = 5'(FLOAT32_MANT_WIDTH) - {2'b00, lead};
    mant_norm = FLOAT32_MANT_WIDTH'(32'(mag) << norm_amt);

    sub_amt  = {1'b0, scale} + 9'(SUBNORMAL_SHIFT_BIAS);
    mant_sub = FLOAT32_MANT_WIDTH'(32'(mag) << sub_amt);

    float32 = '0;
    if (scale == SCALE_NAN) begin
      float32 = FLOAT32_QNAN;
    end else if (element == '0) begin
      float32 = '0;
    end else if (exp_unb >= $signed(10'(FLOAT32_EXP_MAX))) begin
      float32 = FLOAT32_NEG_MAX;
    end else if (exp_unb[9] || (exp_unb == '0)) begin
      float32 = {sign, {FLOAT32_EXP_WIDTH{1'b0}}, mant_sub};
    end else begin
      float32 = {sign, FLOAT32_EXP_WIDTH'(exp_unb), mant_norm};
    end
  end

endmodule

// File: rtl/mxint8_block_dequant_serializer.sv
// Latches one MXINT8 block and streams its elements out as exact float32 beats.
module mxint8_block_dequant_serializer
  import mxint8_block_dequant_serializer_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = MX_BLOCK_SIZE,
  parameter int unsigned IDX_WIDTH  = 5
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_block_valid,
  output logic                                       o_block_ready,
  input  logic [SCALE_WIDTH-1:0]                     i_scale,
  input  logic [BLOCK_SIZE*MXINT8_ELEMENT_WIDTH-1:0] i_mxint8_elements,
  output logic                                       o_valid,
  input  logic                                       i_ready,
  output logic [FLOAT32_WIDTH-1:0]                   o_float32,
  output logic [IDX_WIDTH-1:0]                       o_index,
  output logic                                       o_last
);

  localparam int unsigned          ELEMS_WIDTH = BLOCK_SIZE * MXINT8_ELEMENT_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(BLOCK_SIZE - 1);

  state_t                          state;
  logic [SCALE_WIDTH-1:0]          scale_q;
  logic [ELEMS_WIDTH-1:0]          elems_q;
  logic [IDX_WIDTH-1:0]            idx_q;
  logic [MXINT8_ELEMENT_WIDTH-1:0] cur_elem;
  logic [FLOAT32_WIDTH-1:0]        cur_float;
  logic                            beat_fire;
  logic                            block_fire;

  mxint8_element_to_float32 u_conv (
    .scale   (scale_q),
    .element (cur_elem),
    .float32 (cur_float)
  );

  always_comb begin
    cur_elem      = elems_q[idx_q*MXINT8_ELEMENT_WIDTH +: MXINT8_ELEMENT_WIDTH];
    o_valid       = (state == ST_SEND);
    o_index       = idx_q;
    o_last        = o_valid && (idx_q == LAST_IDX);
    // The final beat's i_ready lets the next block in without a bubble.
    o_block_ready = (state == ST_IDLE) || (o_last && i_ready);
    o_float32     = o_valid ? cur_float : '0;
    beat_fire     = o_valid && i_ready;
    block_fire    = i_block_valid && o_block_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      scale_q <= '0;
      elems_q <= '0;
      idx_q   <= '0;
    end else if (block_fire) begin
      state   <= ST_SEND;
      scale_q <= i_scale;
      elems_q <= i_mxint8_elements;
      idx_q   <= '0;
    end else if (beat_fire) begin
      if (o_last) begin
        state <= ST_IDLE;
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/mxint8_block_dequant_serializer.md
Name: mxint8_block_dequant_serializer

Overview:
Downstream consumer of the broadcast/quantizer stage. Accepts one MXINT8 block (shared E8M0 scale plus BLOCK_SIZE int8 elements) over a valid/ready handshake and registers it. It then emits each element as an exact IEEE-754 float32, one per beat, over a second valid/ready stream. This is the return path from the MX domain to scalar FP32 for checking and for scalar consumers.

Parameters:
BLOCK_SIZE, 32, elements per MX block; must equal the shared `BLOCK_SIZE define.
IDX_WIDTH, 5, element index width; must be at least ceil(log2(BLOCK_SIZE)), and the instantiator sets it.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_block_valid  input  1  upstream block present.
o_block_ready  output  1  block accepted when i_block_valid && o_block_ready.
i_scale  input  8  E8M0 shared scale, bias 127; 0xFF means NaN.
i_mxint8_elements  input  BLOCK_SIZE*8  flattened elements; element k sits in bits [8k+7:8k]; two's complement with 6 fraction bits (value = elem * 2^-6).
o_valid  output  1  float32 beat present.
i_ready  input  1  downstream accepts the beat.
o_float32  output  32  converted element.
o_index  output  IDX_WIDTH  index of the current element.
o_last  output  1  high on the beat carrying element BLOCK_SIZE-1.

Behaviour:
- Reset (asynchronous, any time, including mid-block):
  - State goes to IDLE and the held block is discarded.
  - o_valid=0, o_index=0, o_last=0, o_float32=0; scale and element registers are cleared to 0.
- States:
  - IDLE: o_block_ready=1, o_valid=0.
  - SEND: o_valid=1.
- Transitions:
  - IDLE->SEND on block handshake. Scale and all elements are latched, and the index is set to 0.
  - In SEND, a beat handshake (o_valid && i_ready) advances the index by 1.
  - A handshake with o_last=1 goes to IDLE, unless a new block is accepted in the same cycle.
- Back-to-back blocks: in SEND, o_block_ready = o_last && i_ready. This combinational i_ready->o_block_ready path is intended. A block accepted on the final beat is latched, the index returns to 0, and the state stays in SEND with no bubble.
- Latency: the first beat is valid the cycle after block acceptance. A full block needs BLOCK_SIZE beats with no stalls.
- Output timing: o_float32, o_index and o_last are combinational from registered state only; no input-to-output data path. When o_valid=0, o_float32 is 0. While i_ready=0, the beat and all outputs hold stable.
- Conversion of element e with scale s:
  - s==0xFF: output 0x7FC00000 for every element, regardless of e.
  - e==0: output 0x00000000 (+0, never -0).
  - Otherwise: sign = e[7]; m = |e|, 8-bit unsigned with range 1..128; p = position of the leading one in m (0..7); E = s + p - 6, computed signed at 10 bits.
  - E >= 255 (only possible for e=0x80, s=254): saturate to 0xFF7FFFFF.
  - 1 <= E <= 254: exponent field = E; mantissa = bits of m below the leading one, left-aligned in 23 bits.
  - E <= 0: subnormal; exponent field 0, mantissa = m << (s+16). This always fits 23 bits exactly.
  - All results are exact. No rounding exists in this block.

Decomposition:
- Shared includes (scalar_includes.v / mxint8_includes.v) hold the following; no local magic numbers:
  - `BLOCK_SIZE, `SCALE_WIDTH, `MXINT8_ELEMENT_WIDTH and the FLOAT32 field defines.
  - New: `MXINT8_FRAC_BITS (6), `SCALE_NAN (8'hFF), `FLOAT32_QNAN (32'h7FC00000), `FLOAT32_NEG_MAX (32'hFF7FFFFF).
- Sub-module mxint8_element_to_float32: purely combinational, inputs (scale, element), output float32. It holds the leading-one detect, exponent and subnormal logic. The top level holds the FSM, block registers, index counter and element mux.

Test Plan:
- s=127, elements {0x40, 0xC0, 0x01, 0x00, 0x7F}, rest 0, i_ready=1 -> beats:
  - 0x3F800000, 0xBF800000, 0x3C800000, 0x00000000, 0x3FFE0000;
  - o_index 0..31; o_last only on index 31; first o_valid one cycle after acceptance.
- s=0, e=0x01 -> 0x00010000 (subnormal 2^-133). s=0, e=0xC0 -> 0x80400000. s=254, e=0x80 -> 0xFF7FFFFF. s=254, e=0x7F -> 0x7F7E0000.
- s=0xFF, random elements -> all 32 beats are 0x7FC00000.
- Backpressure: toggle i_ready randomly -> no beat dropped or duplicated; o_float32 and o_index stable while stalled; o_block_ready=0 throughout SEND except on the final beat.
- Back-to-back: second block valid during the first block's last beat -> accepted that cycle; next cycle o_index=0 carries block 2 element 0; exactly 64 beats in 64 cycles at i_ready=1.
- Reset: assert i_rst_n=0 at index 10 with i_clk stopped -> outputs clear immediately. After release, o_block_ready=1 and o_valid=0, and the next block starts at index 0.
